// File: rtl/bus_master_arb_pkg.sv
// Shared definitions for the four-master round-robin bus arbiter.
package bus_master_arb_pkg;

    localparam int unsigned ADDR_W      = 30;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned NUM_MASTERS = 4;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic {
        BUS_ARB_STATE_IDLE = 1'b0,
        BUS_ARB_STATE_BUSY = 1'b1
    } bus_arb_state_e;

    typedef logic [1:0] bus_owner_t;

    localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'd0;
    localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'd1;
    localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'd2;
    localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'd3;

    // Active-low one-hot grant vector for a single owner.
    function automatic logic [3:0] grant_low(input bus_owner_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin picker: first active-low request at or after start, with wrap.
module bus_rr_pick
    import bus_master_arb_pkg::*;
(
    input  logic [3:0] req_,
    input  bus_owner_t start,
    output bus_owner_t idx,
    output logic       valid
);

    bus_owner_t cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        idx   = start;
        valid = 1'b0;
        cand  = start;
        for (int k = 3; k >= 0; k--) begin
            cand = start + 2'(k);
            if (!req_[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_master_arb.sv
// Four-master round-robin arbiter with hold-while-requesting grants and shared-bus mux.
module bus_master_arb
    import bus_master_arb_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 m_req_,
    input  logic [4*ADDR_W-1:0]        m_addr,
    input  logic [3:0]                 m_as_,
    input  logic [3:0]                 m_rw,
    input  logic [4*DATA_W-1:0]        m_wr_data,
    output logic [3:0]                 m_grnt_,
    output logic [ADDR_W-1:0]          s_addr,
    output logic                       s_as_,
    output logic                       s_rw,
    output logic [DATA_W-1:0]          s_wr_data,
    output bus_owner_t                 owner
);

    bus_arb_state_e state;
    bus_owner_t     pick_idx;
    logic           pick_valid;

    // The scan starts past the current owner; a releasing owner has its request high anyway.
    bus_rr_pick u_pick (
        .req_  (m_req_),
        .start (owner + 2'd1),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= BUS_ARB_STATE_IDLE;
            owner   <= BUS_OWNER_MASTER_3;
            m_grnt_ <= 4'b1111;
        end else begin
            unique case (state)
                BUS_ARB_STATE_IDLE: begin
                    if (pick_valid) begin
                        state   <= BUS_ARB_STATE_BUSY;
                        owner   <= pick_idx;
                        m_grnt_ <= grant_low(pick_idx);
                    end
                end
                BUS_ARB_STATE_BUSY: begin
                    if (m_req_[owner]) begin
                        if (pick_valid) begin
                            owner   <= pick_idx;
                            m_grnt_ <= grant_low(pick_idx);
                        end else begin
                            // Owner is kept so the next scan continues fairly.
                            state   <= BUS_ARB_STATE_IDLE;
                            m_grnt_ <= 4'b1111;
                        end
                    end
                end
                default: begin
                    state   <= BUS_ARB_STATE_IDLE;
                    m_grnt_ <= 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        s_addr    = '0;
        s_as_     = DISABLE_;
        s_rw      = READ;
        s_wr_data = '0;
        if (state == BUS_ARB_STATE_BUSY) begin
            s_addr    = m_addr[owner*ADDR_W +: ADDR_W];
            s_as_     = m_as_[owner];
            s_rw      = m_rw[owner];
            s_wr_data = m_wr_data[owner*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_bus_master_arb.sv
// Self-checking bench for bus_master_arb: directed scenarios plus randomized traffic vs. a reference model.
module tb_bus_master_arb;
    import bus_master_arb_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [3:0]           m_req_, m_as_, m_rw;
    logic [4*ADDR_W-1:0]  m_addr;
    logic [4*DATA_W-1:0]  m_wr_data;
    logic [3:0]           m_grnt_;
    logic [ADDR_W-1:0]    s_addr;
    logic                 s_as_, s_rw;
    logic [DATA_W-1:0]    s_wr_data;
    logic [1:0]           owner;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who holds the bus, and the last holder for fairness.
    bit mdl_busy;
    int mdl_owner;
    logic [3:0]        exp_grnt;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_as, exp_rw;
    logic [DATA_W-1:0] exp_wd;

    bus_master_arb dut (
        .clk       (clk),
        .reset     (reset),
        .m_req_    (m_req_),
        .m_addr    (m_addr),
        .m_as_     (m_as_),
        .m_rw      (m_rw),
        .m_wr_data (m_wr_data),
        .m_grnt_   (m_grnt_),
        .s_addr    (s_addr),
        .s_as_     (s_as_),
        .s_rw      (s_rw),
        .s_wr_data (s_wr_data),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    function automatic int rr_next(input logic [3:0] req_n, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (req_n[(from + k) % 4] == 1'b0) return (from + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_comb();
        if (mdl_busy) begin
            exp_grnt = 4'b1111;
            exp_grnt[mdl_owner] = 1'b0;
            exp_addr = m_addr[mdl_owner*ADDR_W +: ADDR_W];
            exp_as   = m_as_[mdl_owner];
            exp_rw   = m_rw[mdl_owner];
            exp_wd   = m_wr_data[mdl_owner*DATA_W +: DATA_W];
        end else begin
            exp_grnt = 4'b1111;
            exp_addr = '0;
            exp_as   = 1'b1;
            exp_rw   = 1'b1;
            exp_wd   = '0;
        end
    endfunction

    task automatic tick();
        int p;
        @(posedge clk);
        p = rr_next(m_req_, mdl_owner);
        if (!mdl_busy) begin
            if (p >= 0) begin
                mdl_busy  = 1'b1;
                mdl_owner = p;
            end
        end else if (m_req_[mdl_owner]) begin
            if (p >= 0) mdl_owner = p;
            else mdl_busy = 1'b0;
        end
        #1;
    endtask

    task automatic set_idle();
        m_req_    = 4'b1111;
        m_as_     = 4'b1111;
        m_rw      = 4'b1111;
        m_addr    = '0;
        m_wr_data = '0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mdl_busy  = 1'b0;
        mdl_owner = 3;
        #3;
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        do_reset();
        n_checks++;
        if (owner !== 2'd3) begin
            n_fail++;
            $display("FAIL reset_owner: got %0d expected 3", owner);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({m_grnt_, s_as_, s_rw, s_addr, s_wr_data} !== {4'b1111, 1'b1, 1'b1, 30'h0, 32'h0}) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got grnt=%b as=%b rw=%b addr=%h wd=%h", c,
                         m_grnt_, s_as_, s_rw, s_addr, s_wr_data);
            end
        end
    endtask

    task automatic test_single_request();
        m_req_ = 4'b1011;
        tick();
        n_checks++;
        if (m_grnt_ !== 4'b1011) begin
            n_fail++;
            $display("FAIL single_grant: got %b expected 1011", m_grnt_);
        end
        m_addr[2*ADDR_W +: ADDR_W]    = 30'h0000_1234;
        m_rw[2]                       = 1'b0;
        m_wr_data[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        m_as_[2]                      = 1'b0;
        #1;
        n_checks++;
        if ({s_addr, s_as_, s_rw, s_wr_data} !== {30'h0000_1234, 1'b0, 1'b0, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL single_mux: got addr=%h as=%b rw=%b wd=%h", s_addr, s_as_, s_rw,
                     s_wr_data);
        end
        m_as_[2] = 1'b1;
        #1;
        n_checks++;
        if (s_as_ !== 1'b1) begin
            n_fail++;
            $display("FAIL single_as_release: got %b expected 1", s_as_);
        end
        m_req_ = 4'b1111;
        tick();
        n_checks++;
        if ({m_grnt_, owner, s_as_} !== {4'b1111, 2'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL single_idle: got grnt=%b owner=%0d as=%b expected 1111/2/1", m_grnt_,
                     owner, s_as_);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int last = -1, tenure = 0, gaps = 0, cur;
        bit started = 1'b0;
        set_idle();
        do_reset();
        m_req_ = 4'b0000;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            tick();
            model_comb();
            n_checks++;
            if (m_grnt_ !== exp_grnt) begin
                n_fail++;
                $display("FAIL rr_grant cyc%0d: got %b expected %b", c, m_grnt_, exp_grnt);
            end
            cur = -1;
            for (int i = 0; i < 4; i++) if (m_grnt_[i] === 1'b0) cur = i;
            if (cur < 0) begin
                if (started) gaps++;
            end else begin
                started = 1'b1;
                if (cur != last) begin
                    order.push_back(cur);
                    last   = cur;
                    tenure = 1;
                end else begin
                    tenure++;
                end
            end
            m_req_ = 4'b0000;
            if (cur >= 0 && tenure == 3) m_req_[cur] = 1'b1;
        end
        n_checks++;
        if (gaps != 0) begin
            n_fail++;
            $display("FAIL rr_gaps: got %0d dead cycles expected 0", gaps);
        end
        n_checks++;
        if (order.size() != 5) begin
            n_fail++;
            $display("FAIL rr_count: got %0d tenures expected 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (order[i] != exp_order[i]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]);
                end
            end
        end
        m_req_ = 4'b1111;
        tick();
    endtask

    task automatic test_hold();
        set_idle();
        do_reset();
        m_req_ = 4'b1101;
        tick();
        n_checks++;
        if (m_grnt_ !== 4'b1101) begin
            n_fail++;
            $display("FAIL hold_first: got %b expected 1101", m_grnt_);
        end
        m_req_ = 4'b1100;
        for (int c = 0; c < 9; c++) begin
            tick();
            n_checks++;
            if (m_grnt_ !== 4'b1101) begin
                n_fail++;
                $display("FAIL hold_keep cyc%0d: got %b expected 1101", c, m_grnt_);
            end
        end
        m_req_ = 4'b1110;
        tick();
        n_checks++;
        if ({m_grnt_, owner} !== {4'b1110, 2'd0}) begin
            n_fail++;
            $display("FAIL hold_handoff: got grnt=%b owner=%0d expected 1110/0", m_grnt_, owner);
        end
        m_req_ = 4'b1111;
        tick();
    endtask

    task automatic test_reset_mid_tenure();
        set_idle();
        do_reset();
        m_req_ = 4'b0111;
        tick();
        n_checks++;
        if (m_grnt_ !== 4'b0111) begin
            n_fail++;
            $display("FAIL midrst_grant: got %b expected 0111", m_grnt_);
        end
        m_as_[3] = 1'b0;
        m_addr[3*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        #1;
        model_comb();
        n_checks++;
        if ({s_as_, s_addr} !== {1'b0, exp_addr}) begin
            n_fail++;
            $display("FAIL midrst_strobe: got as=%b addr=%h expected 0/%h", s_as_, s_addr, exp_addr);
        end
        #2;
        reset     = 1'b1;
        mdl_busy  = 1'b0;
        mdl_owner = 3;
        #1;
        n_checks++;
        if ({m_grnt_, s_as_, s_addr, owner} !== {4'b1111, 1'b1, 30'h0, 2'd3}) begin
            n_fail++;
            $display("FAIL midrst_async: got grnt=%b as=%b addr=%h owner=%0d", m_grnt_, s_as_,
                     s_addr, owner);
        end
        #1;
        reset = 1'b0;
        set_idle();
        m_req_ = 4'b0000;
        tick();
        n_checks++;
        if (m_grnt_ !== 4'b1110) begin
            n_fail++;
            $display("FAIL midrst_first: got %b expected 1110", m_grnt_);
        end
        m_req_ = 4'b1111;
        tick();
    endtask

    task automatic test_nonowner_strobe();
        set_idle();
        do_reset();
        m_req_ = 4'b1101;
        tick();
        m_req_ = 4'b1100;
        m_as_  = 4'b1110;
        #1;
        n_checks++;
        if ({m_grnt_, s_as_} !== {4'b1101, 1'b1}) begin
            n_fail++;
            $display("FAIL nonowner_as: got grnt=%b as=%b expected 1101/1", m_grnt_, s_as_);
        end
        m_as_ = 4'b1100;
        #1;
        n_checks++;
        if (s_as_ !== 1'b0) begin
            n_fail++;
            $display("FAIL owner_as: got %b expected 0", s_as_);
        end
        set_idle();
        tick();
    endtask

    task automatic test_random();
        set_idle();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(3) == 0) m_req_[i] = ~m_req_[i];
                m_addr[i*ADDR_W +: ADDR_W]    = ADDR_W'($urandom);
                m_wr_data[i*DATA_W +: DATA_W] = $urandom;
            end
            m_as_ = 4'($urandom);
            m_rw  = 4'($urandom);
            if ($urandom_range(63) == 0) begin
                reset     = 1'b1;
                mdl_busy  = 1'b0;
                mdl_owner = 3;
                #1;
                n_checks++;
                if ({m_grnt_, s_as_} !== {4'b1111, 1'b1}) begin
                    n_fail++;
                    $display("FAIL rand_reset cyc%0d: got grnt=%b as=%b", c, m_grnt_, s_as_);
                end
                reset = 1'b0;
            end
            #1;
            model_comb();
            n_checks++;
            if ({s_addr, s_as_, s_rw, s_wr_data} !== {exp_addr, exp_as, exp_rw, exp_wd}) begin
                n_fail++;
                $display("FAIL rand_mux cyc%0d: got %h/%b/%b/%h expected %h/%b/%b/%h", c, s_addr,
                         s_as_, s_rw, s_wr_data, exp_addr, exp_as, exp_rw, exp_wd);
            end
            tick();
            model_comb();
            n_checks++;
            if ({m_grnt_, owner} !== {exp_grnt, 2'(mdl_owner)}) begin
                n_fail++;
                $display("FAIL rand_grant cyc%0d: got grnt=%b owner=%0d expected %b/%0d", c,
                         m_grnt_, owner, exp_grnt, mdl_owner);
            end
        end
    endtask

    initial begin
        set_idle();
        reset     = 1'b1;
        mdl_busy  = 1'b0;
        mdl_owner = 3;
        #3;
        test_reset();
        test_single_request();
        test_round_robin();
        test_hold();
        test_reset_mid_tenure();
        test_nonowner_strobe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_master_arb.md
# bus_master_arb

Shared-bus arbiter and master multiplexer for up to four bus masters. Each master is a CPU bus interface or a DMA-style agent using the active-low req_/grnt_ handshake. The block sits directly downstream of each master's bus interface: it consumes their requests and drives their grants. It also routes the granted master's address, strobe, direction and write data onto the single shared slave bus. Arbitration is round-robin, and a grant is held for as long as the owner keeps its request asserted.

## Interface
- ADDR_W, 30, word address width (`WordAddrBus`)
- DATA_W, 32, word data width (`WordDataBus`)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous reset, active-high
- m_req_  in  4  per-master bus request, active-low (bit i = master i)
- m_addr  in  4*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W]
- m_as_  in  4  per-master address strobe, active-low
- m_rw  in  4  per-master read(1)/write(0)
- m_wr_data  in  4*DATA_W  per-master write data, master i at [i*DATA_W +: DATA_W]
- m_grnt_  out  4  per-master bus grant, active-low, registered, one-hot-low or all-high
- s_addr  out  ADDR_W  shared-bus address
- s_as_  out  1  shared-bus address strobe, active-low
- s_rw  out  1  shared-bus read/write
- s_wr_data  out  DATA_W  shared-bus write data
- owner  out  2  index of the current/last owner (debug)

## Operation
- The FSM has two states:
  - IDLE: no grant.
  - BUSY: the master at index `owner` holds the grant.
- Registers: state, owner (2 bits), m_grnt_ (4 bits).
- Reset values:
  - state = IDLE, owner = 3, so master 0 wins first.
  - m_grnt_ = 4'b1111.
  - Shared-bus outputs take their idle values: s_addr = 0, s_as_ = 1, s_rw = 1 (READ), s_wr_data = 0.
- Round-robin pick: scan from (owner+1) mod 4 upward with wrap, and take the first i with m_req_[i] = 0.
- IDLE:
  - If any request is low, go to BUSY, load owner with the pick, and drive m_grnt_[pick] = 0.
  - Otherwise stay in IDLE.
- BUSY, m_req_[owner] = 0: hold the grant. No pre-emption, whatever the other requests.
- BUSY, m_req_[owner] = 1 (release):
  - If another master requests, hand off at the same edge. Owner takes the pick (scanning from old owner+1), the old grant deasserts and the new grant asserts.
  - Otherwise go to IDLE with all grants high. owner keeps the old value so fairness is preserved.
- The releasing master cannot win the pick at the release edge, because its own request is high.
- Shared-bus mux is combinational:
  - In BUSY, s_* = the owner's m_* fields.
  - In IDLE, s_* = the idle values above.
  - Only the granted master's m_as_ can ever reach s_as_.
- A request that drops while not granted is simply never picked. No error is raised.
- Reset asserted mid-transfer immediately returns all grants and outputs to reset values. The slave sees s_as_ = 1 from that point.

## Timing
- Grant latency: request sampled low at edge N gives grnt_ low after edge N (visible in cycle N+1) when the bus is IDLE.
- Handoff costs zero dead cycles: release sampled at edge N gives the new grant after edge N.
- A master must not assert m_as_ before it samples its grant low. The arbiter does not check this; the mux simply blocks a strobe from any non-owner.
- s_* follow the owner's inputs combinationally in the same cycle. There is no added latency on the address/data path.
- Worst-case wait for a continuously requesting master is 3 full tenures.

## Structure
- Shared header bus.h gets:
  - BUS_ARB_STATE_IDLE / BUS_ARB_STATE_BUSY and BusArbStateBus (1 bit).
  - BusOwnerBus (2 bits) and BUS_OWNER_MASTER_0..3.
- Existing READ/WRITE, ENABLE_/DISABLE_ and the width macros are reused.
- One natural sub-module: bus_rr_pick, a combinational round-robin picker. Inputs: req_ [3:0] and start index. Outputs: index and valid flag.
- Everything else lives in bus_master_arb.

## Test plan
- Reset, then m_req_ = 4'b1111 for 5 cycles: m_grnt_ = 4'b1111, s_as_ = 1, s_rw = 1, s_addr = 0, s_wr_data = 0 every cycle.
- After reset, master 2 alone requests at edge 1: m_grnt_ = 4'b1011 from cycle 2. Drive m_addr[2] = 30'h0000_1234, m_rw[2] = 0, m_wr_data[2] = 32'hDEAD_BEEF and pulse m_as_[2]: s_* mirror these in the same cycle.
- All four masters request continuously and each releases 3 cycles after its grant: grant order is 0,1,2,3,0 with no gap cycle between tenures.
- Master 1 owns the bus while master 0 requests: master 1 keeps the grant for its full 10-cycle hold, and master 0 is granted on the edge where master 1's request is sampled high.
- Master 3 owns the bus; pulse reset mid-tenure with m_as_[3] = 0: m_grnt_ = 4'b1111 and s_as_ = 1 immediately (asynchronously). With all four requesting after reset release, master 0 is granted first.
- Non-owner master 0 drives m_as_[0] = 0 while master 1 owns the bus with m_as_[1] = 1: s_as_ stays 1.
